// File: rtl/wb_pkg.sv
// Shared types for the writeback queue.
// Data width and register index width for queued results.
package wb_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/wb_entry_cam.sv
// Match lookup of one operand index against queued writeback entries.
// Youngest-match data select is built only with WB_QUEUE_BYPASS_EN.
module wb_entry_cam
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0]      i_entries,
  input  logic [DEPTH-1:0]           i_valid,
  input  logic [$clog2(DEPTH)-1:0]   i_head,
  input  logic [REG_IDX_W-1:0]       i_query,
  output logic                       o_hit,
  output logic [XLEN-1:0]            o_data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DEPTH-1:0] w_match;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = i_valid[i] && (i_entries[i].rd == i_query);
    end
  end

  assign o_hit = (|w_match) && (i_query != REG_ZERO);

`ifdef WB_QUEUE_BYPASS_EN
  // Walk oldest to youngest so the last match seen wins.
  always_comb begin
    logic [PW-1:0] idx;
    o_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = i_head + PW'(k);
      if (w_match[idx]) begin
        o_data = i_entries[idx].data;
      end
    end
  end
`else
  logic w_unused_cam;
  assign w_unused_cam = ^{i_head, i_entries};
  assign o_data       = '0;
`endif

endmodule

// File: rtl/wb_queue.sv
// In-order writeback serializer for the single register-file write port.
// Optional operand forwarding from queued entries: WB_QUEUE_BYPASS_EN.
module wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src0_valid,
  output logic                 src0_ready,
  input  logic [4:0]           src0_rd,
  input  logic [XLEN-1:0]      src0_data,
  input  logic                 src1_valid,
  output logic                 src1_ready,
  input  logic [4:0]           src1_rd,
  input  logic [XLEN-1:0]      src1_data,
  output logic                 wb_en,
  output logic [4:0]           rd_index,
  output logic [XLEN-1:0]      wb_data,
  input  logic [4:0]           rs1_index,
  input  logic [4:0]           rs2_index,
  output logic                 rs1_pending,
  output logic                 rs2_pending,
  output logic [XLEN-1:0]      rs1_fwd_data,
  output logic [XLEN-1:0]      rs2_fwd_data,
  output logic                 empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic                  w_pop;
  logic                  w_push0;
  logic                  w_push1;
  logic [CW-1:0]         w_free;
  logic [PW-1:0]         w_tail1;
  logic [DEPTH-1:0]      w_valid;
  wb_entry_t             w_head_e;

  assign w_pop  = (r_count != '0);
  assign empty  = !w_pop;

  // The head always retires this cycle, so its slot counts as free.
  assign w_free = DEPTH_C - r_count + CW'(w_pop);

  assign src0_ready = (w_free >= ONE_C);
  assign src1_ready = (w_free > ONE_C)
                   || ((w_free >= ONE_C)
                       && !(src0_valid && (src0_rd != REG_ZERO)));

  assign w_push0 = src0_valid && src0_ready
                && (src0_rd != REG_ZERO);
  assign w_push1 = src1_valid && src1_ready
                && (src1_rd != REG_ZERO);

  assign w_tail1 = r_tail + PW'(w_push0);

  always_ff @(posedge clk) begin
    if (w_push0) begin
      r_mem[r_tail] <= '{rd: src0_rd, data: src0_data};
    end
    if (w_push1) begin
      r_mem[w_tail1] <= '{rd: src1_rd, data: src1_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_push0) + PW'(w_push1);
      r_count <= r_count + CW'(w_push0) + CW'(w_push1)
               - CW'(w_pop);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    logic [PW-1:0] w_off;
    assign w_off      = PW'(g) - r_head;
    assign w_valid[g] = ({1'b0, w_off} < r_count);
  end

  assign w_head_e = r_mem[r_head];
  assign wb_en    = w_pop;
  assign rd_index = w_pop ? w_head_e.rd : REG_ZERO;
  assign wb_data  = w_pop ? w_head_e.data : '0;

  wb_entry_cam #(.DEPTH(DEPTH)) u_cam_rs1 (
    .i_entries (r_mem),
    .i_valid   (w_valid),
    .i_head    (r_head),
    .i_query   (rs1_index),
    .o_hit     (rs1_pending),
    .o_data    (rs1_fwd_data)
  );

  wb_entry_cam #(.DEPTH(DEPTH)) u_cam_rs2 (
    .i_entries (r_mem),
    .i_valid   (w_valid),
    .i_head    (r_head),
    .i_query   (rs2_index),
    .o_hit     (rs2_pending),
    .o_data    (rs2_fwd_data)
  );

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Writeback serializer that drives the single register-file write port (wb_en, rd_index, wb_data).
- Collects results from two producers, ALU (src0) and load unit / cache return (src1), into an in-order FIFO.
- Retires exactly one entry per cycle to the register file.
- Exposes per-source-operand "pending" flags so decode can stall on RAW hazards against queued writes.

Parameters:
- XLEN, 32, data width of results and wb_data.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- src0_valid  in  1  ALU result valid.
- src0_ready  out  1  ALU result accepted this cycle.
- src0_rd  in  5  ALU destination index.
- src0_data  in  XLEN  ALU result.
- src1_valid  in  1  load result valid.
- src1_ready  out  1  load result accepted this cycle.
- src1_rd  in  5  load destination index.
- src1_data  in  XLEN  load result.
- wb_en  out  1  register-file write enable.
- rd_index  out  5  register-file write index.
- wb_data  out  XLEN  register-file write data.
- rs1_index  in  5  decode operand 1 index.
- rs2_index  in  5  decode operand 2 index.
- rs1_pending  out  1  a queued entry targets rs1_index.
- rs2_pending  out  1  a queued entry targets rs2_index.
- rs1_fwd_data  out  XLEN  forwarded operand 1 (optional feature).
- rs2_fwd_data  out  XLEN  forwarded operand 2 (optional feature).
- empty  out  1  FIFO holds no entries.

Behaviour:
- Storage: circular FIFO of {rd, data}, with head/tail pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Reset: async, active-high. Count = 0 and pointers = 0.
  - Outputs during and after reset: wb_en = 0, rd_index = 0, wb_data = 0, empty = 1, all pending = 0, fwd_data = 0.
  - Entry contents are don't-care.
  - Reset asserted mid-operation discards all queued writes. The register file sees no further writes from the discarded entries.
- Write port: combinational from head.
  - wb_en = !empty; rd_index and wb_data = head entry; all three are 0 when empty.
  - The register file always accepts, so the head pops on every cycle with wb_en = 1.
- Latency: a result accepted at edge N is presented on wb_en during cycle N..N+1 at the earliest, and is written to the register file at edge N+1 or later. FIFO order is preserved.
- Free slots: free = DEPTH - count + (count != 0). This credits the same-cycle pop.
- Ready rules:
  - src0_ready = (free >= 1).
  - src1_ready = (free >= 2) || (free >= 1 && !(src0_valid && src0_rd != 0)).
  - Ready does not depend on the source's own valid.
- Push rules:
  - A handshake (valid && ready) with rd == 0 is accepted and dropped; nothing is enqueued.
  - Both sources may push in the same cycle. The src0 entry is enqueued ahead of the src1 entry.
  - Count update: count_next = count + pushes - pop.
- Full: count == DEPTH with no pop does not arise, since a pop always occurs when non-empty. At count == DEPTH, free = 1, so only one push is accepted and src0 has priority.
- Empty with two pushes: both are stored. The src0 entry is written at the next edge, and the src1 entry one cycle later.
- Pending:
  - rsX_pending = 1 iff some valid stored entry, including the head being written this cycle, has rd == rsX_index and rsX_index != 0.
  - Same-cycle incoming pushes are not included; decode covers in-flight producers separately.
- Multiple entries with the same rd retire in order, so the youngest value ends up in the register file.

Optional Feature:
- Macro WB_QUEUE_BYPASS_EN.
- Defined: rsX_fwd_data = data of the youngest valid stored entry with rd == rsX_index (0 if none). Decode uses it instead of stalling when rsX_pending = 1.
- Undefined: rs1_fwd_data and rs2_fwd_data are tied to 0, no match-select logic is built, and pending behaviour is unchanged.

Decomposition:
- Package wb_pkg contains:
  - XLEN default;
  - REG_IDX_W = 5;
  - typedef wb_entry_t {logic [4:0] rd; logic [XLEN-1:0] data;};
  - constant REG_ZERO = 5'd0.
- Sub-module wb_entry_cam: takes the entry array, a valid mask, head pointer and query index. It returns a hit bit and, under the macro, the youngest-match data. It is instantiated once per read operand.

Test Plan:
- Reset with 3 entries queued → next cycle wb_en = 0, empty = 1, pending = 0. No stale write appears after reset release.
- Single ALU push (rd = 5, data = 0xDEADBEEF) at edge N → wb_en = 1, rd_index = 5, wb_data = 0xDEADBEEF in cycle N..N+1, then empty.
- Both sources valid every cycle (src0 rd = 1..n, src1 rd = 17..), DEPTH = 4 →
  - the queue saturates;
  - src1_ready drops once free < 2;
  - write order alternates src0 before src1 per accepted pair;
  - no entry is lost or duplicated.
- Push with rd = 0 (src0_data = 0x1234) → src0_ready = 1, no enqueue, wb_en stays 0.
- Queue holds rd = 7 twice (0x11, then 0x22); rs1_index = 7 →
  - rs1_pending = 1 until the second entry retires;
  - with WB_QUEUE_BYPASS_EN, rs1_fwd_data = 0x22;
  - without the macro, rs1_fwd_data = 0.
- rs2_index = 0 while an entry targets x0 (impossible by the drop rule) or any rd → rs2_pending = 0 always.
